// File: rtl/nn_digit_reader_if.sv
// Handshake bundle between the host, the network controller/datapath and nn_digit_reader.
// slave is the reader's view; master is the view of everything around it.
interface nn_digit_reader_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 4
);
  logic             req;
  logic             busy;
  logic             nnStart;
  logic             nnReady;
  logic [IDX_W-1:0] outSel;
  logic [WIDTH-1:0] outData;
  logic [IDX_W-1:0] digit;
  logic [WIDTH-1:0] maxValue;
  logic             valid;
  logic             ack;

  modport slave (
    input  req, nnReady, outData, ack,
    output busy, nnStart, outSel, digit, maxValue, valid
  );

  modport master (
    output req, nnReady, outData, ack,
    input  busy, nnStart, outSel, digit, maxValue, valid
  );
endinterface

// File: rtl/nn_digit_reader.sv
// Starts one network inference on host request, then scans the output neurons
// through the select mux and reports the argmax digit and its score.
//
// state     | meaning
// IDLE      | waiting for req while the network is ready
// START     | nnStart held until the controller drops nnReady
// WAIT_DONE | inference running, waiting for nnReady to return
// SCAN      | outSel walks 0..NUM_OUT-1, tracking the running maximum
// DONE      | result valid, waiting for ack
module nn_digit_reader #(
  parameter int WIDTH   = 8,
  parameter int NUM_OUT = 10,
  parameter int IDX_W   = 4
) (
  input logic             clk,
  input logic             rst,
  nn_digit_reader_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_DONE,
    SCAN,
    DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] counter;
  logic [IDX_W-1:0] bestIdx;
  logic [WIDTH-1:0] best;
  logic [IDX_W-1:0] digitReg;
  logic [WIDTH-1:0] maxValueReg;
  logic             take;

  // Strict compare keeps the lowest index on ties; index 0 always seeds the search.
  assign take = (counter == '0) || (bus.outData > best);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      counter     <= '0;
      best        <= '0;
      bestIdx     <= '0;
      digitReg    <= '0;
      maxValueReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req && bus.nnReady) state <= START;
        end
        START: begin
          if (!bus.nnReady) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.nnReady) begin
            state   <= SCAN;
            counter <= '0;
          end
        end
        SCAN: begin
          if (take) begin
            best    <= bus.outData;
            bestIdx <= counter;
          end
          // The last neuron is folded in directly so the result is final on entering DONE.
          if (counter == LAST_IDX) begin
            state       <= DONE;
            digitReg    <= take ? counter : bestIdx;
            maxValueReg <= take ? bus.outData : best;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        DONE: begin
          if (bus.ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.nnStart  = (state == START);
  assign bus.valid    = (state == DONE);
  assign bus.outSel   = (state == SCAN) ? counter : '0;
  assign bus.digit    = digitReg;
  assign bus.maxValue = maxValueReg;

endmodule

// File: tb/tb_nn_digit_reader.sv
// Directed bench for nn_digit_reader: a table of output-layer patterns with expected
// argmax, plus hand-written sequences for reset, busy network, held ack and mid-scan reset.
module tb_nn_digit_reader;
  localparam int WIDTH   = 8;
  localparam int NUM_OUT = 10;
  localparam int IDX_W   = 4;
  localparam int NVEC    = 8;

  typedef logic [NUM_OUT-1:0][WIDTH-1:0] pvec_t;
  typedef int ivec_t[NUM_OUT];

  typedef struct {
    pvec_t            data;
    logic [IDX_W-1:0] expDigit;
    logic [WIDTH-1:0] expMax;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst;
  pvec_t curData;
  vec_t  vecs[NVEC];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  nn_digit_reader_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus();

  nn_digit_reader #(.WIDTH(WIDTH), .NUM_OUT(NUM_OUT), .IDX_W(IDX_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Combinational output-layer mux model.
  always_comb begin
    bus.outData = '0;
    if (int'(bus.outSel) < NUM_OUT) bus.outData = curData[bus.outSel];
  end

  function automatic pvec_t packVec(input ivec_t v);
    pvec_t p;
    for (int i = 0; i < NUM_OUT; i++) p[i] = WIDTH'(v[i]);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called with the DUT just having entered START.
  task automatic complete(input int n, input bit doAck);
    bit seqOk;
    curData = vecs[n].data;
    bus.req = 1'b0;
    bus.nnReady = 1'b0;
    tick();
    check("waitBusy", bus.busy, 1);
    check("waitNoStart", bus.nnStart, 0);
    repeat (19) tick();
    bus.nnReady = 1'b1;
    seqOk = 1'b1;
    for (int k = 0; k < NUM_OUT; k++) begin
      tick();
      if (bus.outSel !== k[IDX_W-1:0] || bus.valid !== 1'b0) seqOk = 1'b0;
    end
    check("scanSeq", seqOk, 1);
    tick();
    check("validLatency", bus.valid, 1);
    check("digit", bus.digit, vecs[n].expDigit);
    check("maxValue", bus.maxValue, vecs[n].expMax);
    check("doneOutSel", bus.outSel, 0);
    if (doAck) begin
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      check("ackValidLow", bus.valid, 0);
      check("ackIdle", bus.busy, 0);
    end
  endtask

  task automatic startInference();
    bus.req = 1'b1;
    bus.nnReady = 1'b1;
    tick();
    check("startEntered", bus.nnStart, 1);
  endtask

  initial begin
    ivec_t t;
    t = '{3, 7, 2, 9, 1, 0, 4, 9, 5, 6};           vecs[0].data = packVec(t); vecs[0].expDigit = 3; vecs[0].expMax = 9;
    t = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};           vecs[1].data = packVec(t); vecs[1].expDigit = 9; vecs[1].expMax = 9;
    t = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};           vecs[2].data = packVec(t); vecs[2].expDigit = 0; vecs[2].expMax = 0;
    t = '{255, 255, 255, 255, 255, 255, 255, 255, 255, 255};
                                                   vecs[3].data = packVec(t); vecs[3].expDigit = 0; vecs[3].expMax = 255;
    t = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};           vecs[4].data = packVec(t); vecs[4].expDigit = 0; vecs[4].expMax = 9;
    t = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 200};         vecs[5].data = packVec(t); vecs[5].expDigit = 9; vecs[5].expMax = 200;
    t = '{0, 0, 0, 0, 100, 0, 0, 100, 0, 0};       vecs[6].data = packVec(t); vecs[6].expDigit = 4; vecs[6].expMax = 100;
    t = '{254, 255, 3, 3, 3, 3, 3, 3, 255, 3};     vecs[7].data = packVec(t); vecs[7].expDigit = 1; vecs[7].expMax = 255;

    curData = vecs[0].data;

    // Reset with req and ack asserted.
    rst = 1'b0;
    bus.req = 1'b1;
    bus.ack = 1'b1;
    bus.nnReady = 1'b1;
    tick();
    tick();
    check("rstBusy", bus.busy, 0);
    check("rstValid", bus.valid, 0);
    check("rstStart", bus.nnStart, 0);
    check("rstOutSel", bus.outSel, 0);
    check("rstDigit", bus.digit, 0);
    check("rstMax", bus.maxValue, 0);
    bus.req = 1'b0;
    bus.ack = 1'b0;
    rst = 1'b1;
    tick();
    check("rstNoStart", bus.nnStart, 0);

    // Request while the network is busy is not latched.
    bus.req = 1'b1;
    bus.nnReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("busyNetNoStart", bus.nnStart, 0);
    end
    bus.nnReady = 1'b1;
    tick();
    check("busyNetStart", bus.nnStart, 1);
    complete(0, 1'b1);

    // Held ack with req pulses in DONE.
    startInference();
    complete(1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bus.req = i[0];
      tick();
      check("holdValid", bus.valid, 1);
      check("holdDigit", bus.digit, 9);
      check("holdNoStart", bus.nnStart, 0);
    end
    bus.req = 1'b0;
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check("ackToIdle", bus.busy, 0);
    check("ackValid", bus.valid, 0);
    check("ackDigitKept", bus.digit, 9);
    check("ackMaxKept", bus.maxValue, 9);
    tick();
    check("ackNoRestart", bus.nnStart, 0);

    // Reset in the middle of the scan.
    curData = vecs[1].data;
    startInference();
    bus.req = 1'b0;
    bus.nnReady = 1'b0;
    tick();
    bus.nnReady = 1'b1;
    repeat (5) tick();
    check("midScanSel", bus.outSel, 4);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midRstBusy", bus.busy, 0);
    check("midRstOutSel", bus.outSel, 0);
    check("midRstDigit", bus.digit, 0);
    check("midRstMax", bus.maxValue, 0);
    check("midRstValid", bus.valid, 0);
    check("midRstStart", bus.nnStart, 0);

    // Table sweep, back-to-back with zero-wait ack.
    for (int n = 0; n < NVEC; n++) begin
      startInference();
      complete(n, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
